// File: rtl/eth_rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package eth_rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } eth_speed_e;

  // Nibble packer position within the current byte.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } pack_state_e;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  // Raw speed select to enum: any value with bit 1 set means gigabit.
  function automatic eth_speed_e decode_speed(input logic [1:0] sel);
    if (sel[1]) return SPEED_1000;
    else if (sel[0]) return SPEED_100;
    else return SPEED_10;
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// Decodes RGMII in-band link status from inter-frame idle cycles and only
// accepts a new value once two consecutive idle samples agree.
module rgmii_inband_status (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ctl_1_i,
  input  logic       ctl_2_i,
  input  logic [3:0] rxd_1_i,
  output logic       link_up_o,
  output logic [1:0] link_speed_o,
  output logic       full_duplex_o
);

  logic       idle;
  logic [3:0] prev_q;
  logic       prev_vld_q;
  logic [3:0] status_q;

  // True idle only: frames (dv=1) and false carrier (dv=0, er=1) never count.
  assign idle = ~ctl_1_i & ~ctl_2_i;

  // Track the previous idle sample and commit the status on two matching samples.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q     <= 4'h0;
      prev_vld_q <= 1'b0;
      status_q   <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge value of the others; blocking would chain them within one cycle.
      prev_vld_q <= idle;
      if (idle) begin
        prev_q <= rxd_1_i;
        if (prev_vld_q && (prev_q == rxd_1_i)) status_q <= rxd_1_i;
      end
    end
  end

  assign link_up_o     = status_q[0];
  assign link_speed_o  = status_q[2:1];
  assign full_duplex_o = status_q[3];

endmodule

// File: rtl/rgmii_rx_nibble_pack.sv
// RGMII receive speed adapter: passes DDR nibble pairs through at 1000M and
// packs single-rate nibbles into strobed bytes at 10/100M.
module rgmii_rx_nibble_pack
  import eth_rgmii_pkg::*;
#(
  parameter bit REALIGN_ON_SFD = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] speed_i,
  input  logic [3:0] rxd_1_i,
  input  logic [3:0] rxd_2_i,
  input  logic       ctl_1_i,
  input  logic       ctl_2_i,
  output logic [7:0] gmii_rxd_o,
  output logic       gmii_rx_dv_o,
  output logic       gmii_rx_er_o,
  output logic       gmii_rx_clk_en_o,
  output logic       dribble_o,
  output logic       link_up_o,
  output logic [1:0] link_speed_o,
  output logic       full_duplex_o
);

  logic        dv, er;
  logic [3:0]  nib;
  logic        dv_q;
  eth_speed_e  frame_speed_q, eff_speed;
  pack_state_e state_q, state_d;
  logic [3:0]  low_q, low_d;
  logic        er_lo_q, er_lo_d;
  logic        pre_q, pre_d;     // every nibble so far in this frame was 0x5
  logic        gap_q, gap_d;     // byte-rate phase for idle strobes
  logic [7:0]  rxd_q, rxd_d;
  logic        rx_dv_q, rx_dv_d;
  logic        rx_er_q, rx_er_d;
  logic        clk_en_q, clk_en_d;
  logic        dribble_q, dribble_d;

  assign dv  = ctl_1_i;
  assign er  = ctl_1_i ^ ctl_2_i;
  assign nib = rxd_1_i;

  // The latched speed governs the whole frame, including the DV-fall cycle;
  // on the DV-rise cycle the live speed_i is used (and latched).
  assign eff_speed = dv_q ? frame_speed_q : decode_speed(speed_i);

  // Next-state and next-output logic for the byte assembler.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d   = state_q;
    low_d     = low_q;
    er_lo_d   = er_lo_q;
    pre_d     = pre_q;
    gap_d     = gap_q;
    rxd_d     = rxd_q;
    rx_dv_d   = rx_dv_q;
    rx_er_d   = rx_er_q;
    clk_en_d  = 1'b0;
    dribble_d = 1'b0;

    if (eff_speed == SPEED_1000) begin
      rxd_d    = {rxd_2_i, rxd_1_i};
      rx_dv_d  = dv;
      rx_er_d  = er;
      clk_en_d = 1'b1;
      state_d  = ST_IDLE;
      gap_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (dv) begin
            low_d   = nib;
            er_lo_d = er;
            pre_d   = (nib == NIB_PRE);
            gap_d   = 1'b0;
            state_d = ST_HIGH;
          end else begin
            clk_en_d = gap_q;
            rx_dv_d  = 1'b0;
            rx_er_d  = 1'b0;
            gap_d    = ~gap_q;
          end
        end
        ST_LOW: begin
          if (!dv) begin
            // Frame closed on a byte boundary: one trailing gap strobe.
            clk_en_d = 1'b1;
            rx_dv_d  = 1'b0;
            rx_er_d  = 1'b0;
            state_d  = ST_IDLE;
          end else if (REALIGN_ON_SFD && pre_q && (nib == NIB_SFD)) begin
            // SFD landed on a low slot: reuse the last preamble nibble as low.
            rxd_d    = {NIB_SFD, NIB_PRE};
            rx_dv_d  = 1'b1;
            rx_er_d  = er;
            clk_en_d = 1'b1;
            pre_d    = 1'b0;
          end else begin
            low_d   = nib;
            er_lo_d = er;
            pre_d   = pre_q && (nib == NIB_PRE);
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (!dv) begin
            // Odd nibble pending: drop it and flag the dribble.
            dribble_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            rxd_d    = {nib, low_q};
            rx_dv_d  = 1'b1;
            rx_er_d  = er_lo_q | er;
            clk_en_d = 1'b1;
            pre_d    = pre_q && (nib == NIB_PRE);
            state_d  = ST_LOW;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, frame-speed latch and registered GMII outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: every register is reset (no storage arrays here), so a reset
      // mid-frame discards the partial byte and leaves no stale strobe.
      state_q       <= ST_IDLE;
      frame_speed_q <= SPEED_1000;
      dv_q          <= 1'b0;
      low_q         <= 4'h0;
      er_lo_q       <= 1'b0;
      pre_q         <= 1'b0;
      gap_q         <= 1'b0;
      rxd_q         <= 8'h00;
      rx_dv_q       <= 1'b0;
      rx_er_q       <= 1'b0;
      clk_en_q      <= 1'b0;
      dribble_q     <= 1'b0;
    end else begin
      if (dv && !dv_q) frame_speed_q <= decode_speed(speed_i);
      dv_q      <= dv;
      state_q   <= state_d;
      low_q     <= low_d;
      er_lo_q   <= er_lo_d;
      pre_q     <= pre_d;
      gap_q     <= gap_d;
      rxd_q     <= rxd_d;
      rx_dv_q   <= rx_dv_d;
      rx_er_q   <= rx_er_d;
      clk_en_q  <= clk_en_d;
      dribble_q <= dribble_d;
    end
  end

  assign gmii_rxd_o       = rxd_q;
  assign gmii_rx_dv_o     = rx_dv_q;
  assign gmii_rx_er_o     = rx_er_q;
  assign gmii_rx_clk_en_o = clk_en_q;
  assign dribble_o        = dribble_q;

  rgmii_inband_status u_inband (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ctl_1_i       (ctl_1_i),
    .ctl_2_i       (ctl_2_i),
    .rxd_1_i       (rxd_1_i),
    .link_up_o     (link_up_o),
    .link_speed_o  (link_speed_o),
    .full_duplex_o (full_duplex_o)
  );

endmodule

// File: tb/tb_rgmii_rx_nibble_pack.sv
// Self-checking bench for rgmii_rx_nibble_pack: directed spec scenarios plus
// randomized 10/100 frames scored against a nibble-list reference model.
module tb_rgmii_rx_nibble_pack;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [1:0] speed_i;
  logic [3:0] rxd_1_i, rxd_2_i;
  logic       ctl_1_i, ctl_2_i;
  logic [7:0] gmii_rxd_o;
  logic       gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_clk_en_o, dribble_o;
  logic       link_up_o, full_duplex_o;
  logic [1:0] link_speed_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] nib_a [64];
  logic       er_a  [64];
  logic [8:0] got_q [$];
  int         got_cyc [$];
  int         drib_cnt;

  always #5 clk = ~clk;

  rgmii_rx_nibble_pack #(.REALIGN_ON_SFD(1'b1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .speed_i          (speed_i),
    .rxd_1_i          (rxd_1_i),
    .rxd_2_i          (rxd_2_i),
    .ctl_1_i          (ctl_1_i),
    .ctl_2_i          (ctl_2_i),
    .gmii_rxd_o       (gmii_rxd_o),
    .gmii_rx_dv_o     (gmii_rx_dv_o),
    .gmii_rx_er_o     (gmii_rx_er_o),
    .gmii_rx_clk_en_o (gmii_rx_clk_en_o),
    .dribble_o        (dribble_o),
    .link_up_o        (link_up_o),
    .link_speed_o     (link_speed_o),
    .full_duplex_o    (full_duplex_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] spd, input logic c1, input logic c2,
                       input logic [3:0] r1, input logic [3:0] r2);
    speed_i = spd;
    ctl_1_i = c1;
    ctl_2_i = c2;
    rxd_1_i = r1;
    rxd_2_i = r2;
  endtask

  // Advance one clock and sample the outputs just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (gmii_rx_clk_en_o && gmii_rx_dv_o) begin
      got_q.push_back({gmii_rx_er_o, gmii_rxd_o});
      got_cyc.push_back(cyc);
    end
    if (dribble_o) drib_cnt++;
  endtask

  // Preamble of p 0x5 nibbles then SFD; returns the index after the SFD.
  task automatic load_preamble(input int p, output int next);
    for (int i = 0; i < p; i++) begin nib_a[i] = 4'h5; er_a[i] = 1'b0; end
    nib_a[p] = 4'hD;
    er_a[p]  = 1'b0;
    next = p + 1;
  endtask

  // Drive nib_a[0..n-1] as one frame and score it against the reference rules.
  task automatic run_frame(input string tag, input int n, input logic [1:0] spd_idle,
                           input logic [1:0] spd_frame, input logic [1:0] spd_mid,
                           input int mid_idx);
    logic [8:0] exp_q [$];
    int p, start, exp_drib;
    for (int i = 0; i < 3; i++) begin drive(spd_idle, 1'b0, 1'b0, 4'h0, 4'h0); step(); end
    got_q.delete();
    got_cyc.delete();
    drib_cnt = 0;
    for (int i = 0; i < n; i++) begin
      drive((i >= mid_idx) ? spd_mid : spd_frame, 1'b1, ~er_a[i], nib_a[i], nib_a[i]);
      step();
    end
    for (int i = 0; i < 4; i++) begin drive(spd_frame, 1'b0, 1'b0, 4'h0, 4'h0); step(); end

    // Reference: leading 0x5 run followed by 0xD gives floor(p/2) bytes of 0x55
    // then 0xD5 with the SFD byte-aligned; the rest pairs low-nibble-first.
    p = 0;
    while (p < n && nib_a[p] == 4'h5) p++;
    start = 0;
    if (p >= 1 && p < n && nib_a[p] == 4'hD) begin
      for (int k = 0; k < p / 2; k++) exp_q.push_back({er_a[2*k] | er_a[2*k+1], 8'h55});
      exp_q.push_back({er_a[p] | ((p % 2 == 1) ? er_a[p-1] : 1'b0), 8'hD5});
      start = p + 1;
    end
    for (int k = start; k + 1 < n; k += 2)
      exp_q.push_back({er_a[k] | er_a[k+1], nib_a[k+1], nib_a[k]});
    exp_drib = ((n - start) % 2 == 1) ? 1 : 0;

    check({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d {er,data}", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " dribble cycles"}, drib_cnt, exp_drib);
  endtask

  function automatic logic [3:0] status_of(input logic [3:0] r);
    return {r[0], r[2:1], r[3]};
  endfunction

  initial begin
    logic [3:0] r1, r2;
    logic       c1, c2;
    int         nx, ng, p, len;
    logic [1:0] spd;

    // Reset: all outputs low.
    rst_ni = 1'b0;
    drive(2'b10, 1'b1, 1'b0, 4'hA, 4'h3);
    step();
    step();
    check("reset outputs", 32'({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_clk_en_o,
                               dribble_o, link_up_o, link_speed_o, full_duplex_o}), 32'h0);

    // 1000M pass-through.
    rst_ni = 1'b1;
    drive(2'b10, 1'b1, 1'b1, 4'h5, 4'hD);
    step();
    check("1G D5 {rxd,dv,er,en}", 32'({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_clk_en_o}),
          32'({8'hD5, 1'b1, 1'b0, 1'b1}));
    for (int i = 0; i < 8; i++) begin
      r1 = 4'($urandom_range(0, 15));
      r2 = 4'($urandom_range(0, 15));
      c1 = 1'($urandom_range(0, 1));
      c2 = 1'($urandom_range(0, 1));
      drive(2'b10, c1, c2, r1, r2);
      step();
      check($sformatf("1G rand%0d {rxd,dv,er,en}", i),
            32'({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_clk_en_o}),
            32'({r2, r1, c1, c1 ^ c2, 1'b1}));
    end

    // 100M: 15 preamble nibbles, SFD, payload 0x12; strobes exactly 2 cycles apart.
    load_preamble(15, nx);
    nib_a[nx] = 4'h2; er_a[nx] = 1'b0;
    nib_a[nx+1] = 4'h1; er_a[nx+1] = 1'b0;
    run_frame("100M p15", nx + 2, 2'b01, 2'b01, 2'b01, 99);
    ng = 0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 2) ng++;
    check("100M p15 strobe spacing", ng, 0);

    // 100M: even preamble length forces SFD realignment.
    load_preamble(14, nx);
    nib_a[nx] = 4'h7; er_a[nx] = 1'b0;
    nib_a[nx+1] = 4'hA; er_a[nx+1] = 1'b0;
    run_frame("100M p14 realign", nx + 2, 2'b01, 2'b01, 2'b01, 99);

    // 100M: odd nibble count -> last byte dropped, one-cycle dribble.
    load_preamble(7, nx);
    for (int i = 0; i < 3; i++) begin nib_a[nx+i] = 4'(i + 1); er_a[nx+i] = 1'b0; end
    run_frame("100M odd", nx + 3, 2'b01, 2'b01, 2'b01, 99);

    // 10M: error on one nibble of byte 0x34 only.
    load_preamble(7, nx);
    nib_a[nx]   = 4'h1; nib_a[nx+1] = 4'h2;
    nib_a[nx+2] = 4'h4; nib_a[nx+3] = 4'h3;
    nib_a[nx+4] = 4'h5; nib_a[nx+5] = 4'h6;
    for (int i = 0; i < 6; i++) er_a[nx+i] = 1'b0;
    er_a[nx+3] = 1'b1;
    run_frame("10M er", nx + 6, 2'b00, 2'b00, 2'b00, 99);

    // Mid-frame speed_i changes are ignored until DV falls.
    load_preamble(7, nx);
    for (int i = 0; i < 8; i++) begin nib_a[nx+i] = 4'(15 - i); er_a[nx+i] = 1'b0; end
    run_frame("100M->10M mid", nx + 8, 2'b01, 2'b01, 2'b00, 10);
    load_preamble(9, nx);
    for (int i = 0; i < 5; i++) begin nib_a[nx+i] = 4'(3 * i); er_a[nx+i] = 1'b0; end
    run_frame("100M->1G mid", nx + 5, 2'b01, 2'b01, 2'b10, 12);

    // DV rise on the same cycle as a 1000M -> 100M change latches 100M.
    load_preamble(8, nx);
    nib_a[nx] = 4'hC; nib_a[nx+1] = 4'h3; er_a[nx] = 1'b0; er_a[nx+1] = 1'b0;
    run_frame("1G->100M at DV rise", nx + 2, 2'b10, 2'b01, 2'b01, 99);

    // Randomized 10/100 frames.
    for (int f = 0; f < 6; f++) begin
      p   = $urandom_range(1, 15);
      len = $urandom_range(0, 12);
      spd = 2'($urandom_range(0, 1));
      load_preamble(p, nx);
      for (int i = 0; i < len; i++) begin
        nib_a[nx+i] = 4'($urandom_range(0, 15));
        er_a[nx+i]  = ($urandom_range(0, 7) == 0);
      end
      run_frame($sformatf("rand frame%0d", f), nx + len, spd, spd, spd, 99);
    end

    // In-band status (1000M so frames do not disturb packing state).
    for (int i = 0; i < 2; i++) begin drive(2'b10, 1'b0, 1'b0, 4'h0, 4'h0); step(); end
    check("inband zero", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(status_of(4'h0)));
    for (int i = 0; i < 3; i++) begin drive(2'b10, 1'b0, 1'b1, 4'hD, 4'hD); step(); end
    check("inband false carrier hold", 32'({link_up_o, link_speed_o, full_duplex_o}),
          32'(status_of(4'h0)));
    drive(2'b10, 1'b0, 1'b0, 4'hD, 4'hD); step();
    check("inband single D", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(status_of(4'h0)));
    drive(2'b10, 1'b0, 1'b0, 4'hD, 4'hD); step();
    check("inband D twice", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(4'b1_10_1));
    drive(2'b10, 1'b0, 1'b0, 4'h0, 4'h0); step();
    check("inband glitch 0", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(4'b1_10_1));
    drive(2'b10, 1'b0, 1'b0, 4'hD, 4'hD); step();
    check("inband after glitch", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(4'b1_10_1));
    for (int i = 0; i < 3; i++) begin drive(2'b10, 1'b1, 1'b1, 4'h2, 4'h2); step(); end
    check("inband frame hold", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(4'b1_10_1));
    drive(2'b10, 1'b0, 1'b0, 4'h2, 4'h2); step();
    check("inband single 2", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(4'b1_10_1));
    drive(2'b10, 1'b0, 1'b0, 4'h2, 4'h2); step();
    check("inband 2 twice", 32'({link_up_o, link_speed_o, full_duplex_o}), 32'(status_of(4'h2)));
    for (int i = 0; i < 2; i++) begin drive(2'b10, 1'b0, 1'b0, 4'hD, 4'hD); step(); end

    // Reset mid-frame at 100M: outputs clear, no strobe or dribble afterwards.
    for (int i = 0; i < 2; i++) begin drive(2'b01, 1'b0, 1'b0, 4'hD, 4'hD); step(); end
    for (int i = 0; i < 5; i++) begin drive(2'b01, 1'b1, 1'b1, 4'h5, 4'h5); step(); end
    rst_ni = 1'b0;
    step();
    check("reset mid-frame outputs", 32'({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_clk_en_o,
                                         dribble_o, link_up_o, link_speed_o, full_duplex_o}), 32'h0);
    rst_ni = 1'b1;
    drive(2'b01, 1'b0, 1'b0, 4'h0, 4'h0);
    drib_cnt = 0;
    got_q.delete();
    for (int i = 0; i < 3; i++) step();
    check("post-reset dribble", drib_cnt, 0);
    check("post-reset data strobes", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
